// File: rtl/reg_dump_ctrl.sv
// Debug register-file dump engine: halts the core, walks an address range
// through a spare read port and streams {addr, value} pairs out.
module reg_dump_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_dout,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_dout_data;
    logic [ADDR_W-1:0] r_dout_addr;
    logic              r_dout_valid;
    logic              w_xfer;
    logic              w_abort;
    logic              w_at_last;

    assign w_xfer    = r_dout_valid & dout_ready;
    assign w_abort   = abort & (r_state != S_IDLE);
    assign w_at_last = (r_cur == r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start) w_next = S_HALT_WAIT;
            S_HALT_WAIT: if (halt_ack) w_next = S_READ;
            S_READ:      if (halt_ack) w_next = S_HOLD;
            S_HOLD: begin
                if (w_xfer) w_next = w_at_last ? S_DONE : S_READ;
            end
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        // Abort overrides everything, even a transfer in the same cycle.
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= '0;
            r_last       <= '0;
            r_dout_data  <= '0;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_cur  <= first_addr;
                r_last <= last_addr;
            end
            if (w_abort) begin
                r_dout_valid <= 1'b0;
            end else if (r_state == S_READ && halt_ack) begin
                r_dout_data  <= rf_dout;
                r_dout_addr  <= r_cur;
                r_dout_valid <= 1'b1;
            end else if (r_state == S_HOLD && w_xfer) begin
                r_dout_valid <= 1'b0;
                if (!w_at_last) r_cur <= r_cur + 1'b1;
            end
        end
    end

    assign halt_req   = (r_state == S_HALT_WAIT) |
                        (r_state == S_READ) |
                        (r_state == S_HOLD);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rf_addr    = r_cur;
    assign dout_data  = r_dout_data;
    assign dout_addr  = r_dout_addr;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a behavioural register file
// and a negedge transfer monitor.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic        abort = 1'b0;
    logic        halt_req;
    logic        halt_ack = 1'b0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_dout;
    logic [31:0] dout_data;
    logic [4:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];
    assign rf_dout = mem[rf_addr];

    int errors = 0;
    int checks = 0;

    reg_dump_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_addr(rf_addr), .rf_dout(rf_dout),
        .dout_data(dout_data), .dout_addr(dout_addr),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: at negedge, inputs/outputs equal what the next posedge sees.
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [4:0]  prev_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid && dout_ready) begin
                q_addr.push_back(dout_addr);
                q_data.push_back(dout_data);
                q_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && dout_valid &&
                (dout_data != prev_data || dout_addr != prev_addr))
                stab_err++;
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_addr  = dout_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        done_cnt = 0;
        stab_err = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, bound);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(3000);
    endtask

    task automatic test_reset();
        checks++;
        if ({halt_req, dout_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0000", {halt_req, dout_valid, busy, done});
        end
        checks++;
        if ({rf_addr, dout_addr, dout_data} !== 42'd0) begin
            errors++;
            $display("FAIL reset_data: rf_addr=%0d dout_addr=%0d dout_data=%h want 0",
                     rf_addr, dout_addr, dout_data);
        end
    endtask

    task automatic test_full_dump();
        int bad_gap;
        clear_mon();
        halt_ack   = 1'b1;
        dout_ready = 1'b1;
        run_dump(5'd0, 5'd31);
        checks++;
        if (q_addr.size() != 32) begin
            errors++;
            $display("FAIL full_count: got %0d want 32", q_addr.size());
        end
        for (int i = 0; i < 32 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== 5'(i) || q_data[i] !== 32'h100 + i) begin
                errors++;
                $display("FAIL full_word%0d: got a=%0d d=%h want a=%0d d=%h",
                         i, q_addr[i], q_data[i], i, 32'h100 + i);
            end
        end
        bad_gap = 0;
        for (int i = 1; i < q_cyc.size(); i++)
            if (q_cyc[i] - q_cyc[i-1] != 2) bad_gap++;
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL full_spacing: got %0d bad gaps want 0", bad_gap);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL full_done_cnt: got %0d want 1", done_cnt);
        end
        if (q_cyc.size() > 0) begin
            checks++;
            if (done_cyc != q_cyc[q_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL full_done_time: got cyc %0d want %0d",
                         done_cyc, q_cyc[q_cyc.size()-1] + 1);
            end
        end
        checks++;
        if (halt_req !== 1'b0) begin
            errors++;
            $display("FAIL full_halt_after: got %b want 0", halt_req);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_a [4];
        exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
        clear_mon();
        run_dump(5'd30, 5'd1);
        checks++;
        if (q_addr.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 4", q_addr.size());
        end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== exp_a[i] || q_data[i] !== 32'h100 + exp_a[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: got a=%0d d=%h want a=%0d d=%h",
                         i, q_addr[i], q_data[i], exp_a[i], 32'h100 + exp_a[i]);
            end
        end
        clear_mon();
        run_dump(5'd7, 5'd7);
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 5'd7 || q_data[0] !== 32'h107) begin
            errors++;
            $display("FAIL single_word: got n=%0d a=%0d d=%h want n=1 a=7 d=107",
                     q_addr.size(), q_addr.size() ? q_addr[0] : 5'd0,
                     q_data.size() ? q_data[0] : 32'd0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        clear_mon();
        first_addr = 5'd3;
        last_addr  = 5'd12;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            dout_ready = ($urandom_range(0, 99) < 30);
            @(posedge clk); #1;
            n++;
        end
        dout_ready = 1'b1;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL bp_timeout: busy=%0b want 0", busy);
        end
        checks++;
        if (q_addr.size() != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d want 10", q_addr.size());
        end
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 5'(3 + i) || q_data[i] !== 32'h103 + i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_order: got %0d wrong words want 0", bad);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err);
        end
    endtask

    task automatic test_halt();
        int bad;
        clear_mon();
        halt_ack   = 1'b0;
        dout_ready = 1'b0;
        first_addr = 5'd0;
        last_addr  = 5'd3;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!halt_req || dout_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_wait: got %0d bad cycles want 0", bad);
        end
        halt_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_lat1: got valid=%b want 0", dout_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_addr !== 5'd0 || dout_data !== 32'h100) begin
            errors++;
            $display("FAIL halt_lat2: got v=%b a=%0d d=%h want v=1 a=0 d=100",
                     dout_valid, dout_addr, dout_data);
        end
        halt_ack   = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        repeat (3) begin
            if (dout_valid || !busy) bad++;
            @(posedge clk); #1;
        end
        if (dout_valid) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_stall: got %0d bad cycles want 0", bad);
        end
        halt_ack = 1'b1;
        wait_idle(200);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 5'(i) || q_data[i] !== 32'h100 + i) bad++;
        checks++;
        if (q_addr.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL halt_resume: got n=%0d bad=%0d want n=4 bad=0",
                     q_addr.size(), bad);
        end
    endtask

    task automatic test_abort();
        int n;
        int bad;
        clear_mon();
        halt_ack   = 1'b1;
        dout_ready = 1'b1;
        first_addr = 5'd0;
        last_addr  = 5'd31;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(dout_valid && dout_addr == 5'd5) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        dout_ready = 1'b0;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({busy, dout_valid, halt_req} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: got busy,valid,halt=%b want 000",
                     {busy, dout_valid, halt_req});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || q_addr.size() != 5) begin
            errors++;
            $display("FAIL abort_words: got done=%0d n=%0d want done=0 n=5",
                     done_cnt, q_addr.size());
        end
        clear_mon();
        dout_ready = 1'b1;
        run_dump(5'd10, 5'd12);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 5'(10 + i) || q_data[i] !== 32'h10A + i) bad++;
        checks++;
        if (q_addr.size() != 3 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: got n=%0d bad=%0d done=%0d want 3/0/1",
                     q_addr.size(), bad, done_cnt);
        end
    endtask

    task automatic test_start_busy();
        int n;
        int bad;
        clear_mon();
        first_addr = 5'd0;
        last_addr  = 5'd7;
        start      = 1'b1;
        @(posedge clk); #1;
        first_addr = 5'd20;
        last_addr  = 5'd25;
        n = 0;
        while (busy && n < 200) begin
            start = !done;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 5'(i) || q_data[i] !== 32'h100 + i) bad++;
        checks++;
        if (q_addr.size() != 8 || bad != 0 || done_cnt != 1 || busy) begin
            errors++;
            $display("FAIL start_busy: got n=%0d bad=%0d done=%0d busy=%b want 8/0/1/0",
                     q_addr.size(), bad, done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        first_addr = 5'd0;
        last_addr  = 5'd31;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({halt_req, dout_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ctl: got %b want 0000",
                     {halt_req, dout_valid, busy, done});
        end
        checks++;
        if ({rf_addr, dout_addr, dout_data} !== 42'd0) begin
            errors++;
            $display("FAIL rst_mid_data: rf_addr=%0d a=%0d d=%h want 0",
                     rf_addr, dout_addr, dout_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || busy) begin
            errors++;
            $display("FAIL rst_mid_done: got done=%0d busy=%b want 0/0", done_cnt, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_halt();
        test_abort();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
Debug read-out engine for the CPU register file. On request it halts the core, walks a range of register addresses through a spare asynchronous read port, and streams each {address, value} pair out over a valid/ready interface to the debug link. It is the reading end of the register-file interface: it drives the read address and consumes the combinational read data. Instantiated next to reg_file, between the core and the debug transport.

Parameters:
ADDR_W, 5, register address width; 2**ADDR_W registers.
DATA_W, 32, register data width.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  begin dump; sampled only in IDLE.
first_addr  in  ADDR_W  first register of the range; latched on accepted start.
last_addr  in  ADDR_W  last register of the range; latched on accepted start.
abort  in  1  cancel an in-progress dump.
halt_req  out  1  request core halt; high while the dump owns the file.
halt_ack  in  1  core halted; register file stable.
rf_addr  out  ADDR_W  read address to the register-file read port.
rf_dout  in  DATA_W  combinational read data for rf_addr.
dout_data  out  DATA_W  captured register value.
dout_addr  out  ADDR_W  address of dout_data.
dout_valid  out  1  output word valid.
dout_ready  in  1  sink accepts the word.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last word transfers.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. halt_req, rf_addr, dout_data, dout_addr, dout_valid, busy and done are all 0. Internal cur and last are 0. Reset mid-dump discards the dump with no done.
- States: IDLE, HALT_WAIT, READ, HOLD, DONE.
- IDLE: start=1 -> cur<=first_addr, last<=last_addr -> HALT_WAIT.
- HALT_WAIT: halt_req=1. halt_ack=1 -> READ. Otherwise stay; no timeout.
- READ: rf_addr=cur (registered, held). The register file writes on negedge, so the capture is on posedge.
  - If halt_ack=1: dout_data<=rf_dout, dout_addr<=cur, dout_valid<=1 -> HOLD.
  - If halt_ack=0: stall in READ, no capture.
- HOLD: dout_valid=1. dout_data and dout_addr stay stable until the transfer.
  - Transfer = dout_valid & dout_ready at posedge. On transfer dout_valid<=0.
  - If cur==last -> DONE; else cur<=cur+1 (mod 2**ADDR_W) -> READ.
- DONE: done=1 for exactly one cycle; halt_req<=0 -> IDLE.
- Throughput: at most one word per 2 cycles. Latency from halt_ack=1 (in HALT_WAIT) to first dout_valid is 2 cycles.
- Range: count = ((last-first) mod 2**ADDR_W) + 1.
  - first==last: one word.
  - first>last wraps: 30..1 gives 30,31,0,1.
  - 0..31 gives all 32 words; no empty range exists.
- halt_req is high in HALT_WAIT, READ and HOLD; low in IDLE and DONE.
- busy is high in all non-IDLE states, including DONE.
- start while busy: ignored, with no effect on latched range.
- abort=1 in any non-IDLE state -> IDLE next cycle. dout_valid<=0, halt_req<=0, no done pulse.
  - Transfer in the same cycle as abort: the word counts as delivered, and the abort still wins.
  - abort in IDLE: ignored.
  - abort with start in IDLE: start is accepted.
- The block never writes the register file.

Test Plan:
- Full dump: registers preloaded with reg[i]=0x100+i, first=0, last=31, halt_ack tied 1, dout_ready=1 -> 32 words, addr 0..31 in order with data 0x100..0x11F. Words 2 cycles apart; done pulses once, 1 cycle after last transfer; halt_req then 0.
- Wrap range: first=30, last=1 -> exactly 4 words, addresses 30,31,0,1 with matching data. Single range first=last=7 -> one word, addr 7.
- Backpressure: dout_ready random 30% -> dout_data/dout_addr never change while valid & !ready; no word lost or duplicated; order preserved.
- Halt handshake: halt_ack delayed 10 cycles -> halt_req=1 and dout_valid=0 throughout; first word 2 cycles after ack. halt_ack dropped for 3 cycles during READ -> stall, correct data resumes.
- Abort: abort in HOLD at word 5 of 0..31 -> IDLE next cycle, dout_valid=0, halt_req=0, done never pulses. A following start dumps the new range correctly.
- Ignored events and reset: start pulsed while busy -> range unchanged, word count unchanged. rst_n low mid-dump -> all outputs 0 immediately (async), no done.
